// File: rtl/stream_packetizer.sv
// Stream packetizer: buffers 16-bit words from the core in a FIFO and emits
// fixed-length UART packets, low byte first, toward the UART transmitter.

package Structures;
    typedef struct packed {
        logic [7:0] Source;
        logic [7:0] Destination;
        logic [7:0] Length;
        logic       SoP;
        logic       EoP;
        logic [7:0] Data;
        logic       Valid;
    } UART_PACKET;
endpackage

module stream_packetizer
    import Structures::*;
#(
    parameter int         FIFO_DEPTH       = 256,
    parameter int         WORDS_PER_PACKET = 4,
    parameter logic [7:0] DEST             = 8'h10,
    parameter logic [7:0] SRC              = 8'h00
) (
    input  logic                          ipClk,
    input  logic                          ipReset,
    input  logic [15:0]                   ipStream,
    input  logic                          ipValid,
    output logic                          opReady,
    output UART_PACKET                    opTxStream,
    input  logic                          ipTxReady,
    output logic [$clog2(FIFO_DEPTH):0]   opFIFO_Size,
    output logic                          opOverflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] WPP_C   = CW'(WORDS_PER_PACKET);
    localparam logic [6:0]    WPP_K   = 7'(WORDS_PER_PACKET);
    localparam logic [7:0]    LEN_C   = 8'(2 * WORDS_PER_PACKET);

    typedef enum logic [1:0] {IDLE, SEND_LOW, SEND_HIGH} state_t;

    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [15:0]   head;
    logic          push, pop, xfer;

    state_t     state, state_nxt;
    logic [7:0] w_high, w_high_nxt;
    logic [6:0] k, k_nxt;
    logic [7:0] data_nxt;
    logic       sop_nxt, eop_nxt, valid_nxt;

    assign head        = mem[rd_ptr];
    assign opReady     = (count < DEPTH_C);
    assign opFIFO_Size = count;
    assign xfer        = opTxStream.Valid && ipTxReady;
    // A pop in the same cycle frees a slot, so a write into a full FIFO still succeeds.
    assign push        = ipValid && (opReady || pop);

    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            opOverflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (ipValid && !push) opOverflow <= 1'b1;
        end
    end

    // NOTE: storage array is deliberately not reset; only pointers and count define its contents.
    always_ff @(posedge ipClk) begin
        if (push) mem[wr_ptr] <= ipStream;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_nxt  = state;
        w_high_nxt = w_high;
        k_nxt      = k;
        data_nxt   = opTxStream.Data;
        sop_nxt    = opTxStream.SoP;
        eop_nxt    = opTxStream.EoP;
        valid_nxt  = opTxStream.Valid;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                valid_nxt = 1'b0;
                if (count >= WPP_C) begin
                    pop        = 1'b1;
                    w_high_nxt = head[15:8];
                    k_nxt      = 7'd1;
                    data_nxt   = head[7:0];
                    sop_nxt    = 1'b1;
                    eop_nxt    = 1'b0;
                    valid_nxt  = 1'b1;
                    state_nxt  = SEND_LOW;
                end
            end
            SEND_LOW: begin
                if (xfer) begin
                    data_nxt  = w_high;
                    sop_nxt   = 1'b0;
                    eop_nxt   = (k == WPP_K);
                    state_nxt = SEND_HIGH;
                end
            end
            SEND_HIGH: begin
                if (xfer) begin
                    if (k < WPP_K) begin
                        pop        = 1'b1;
                        w_high_nxt = head[15:8];
                        k_nxt      = k + 7'd1;
                        data_nxt   = head[7:0];
                        eop_nxt    = 1'b0;
                        state_nxt  = SEND_LOW;
                    end else begin
                        valid_nxt = 1'b0;
                        eop_nxt   = 1'b0;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) begin
            state      <= IDLE;
            w_high     <= '0;
            k          <= '0;
            opTxStream <= '0;
        end else begin
            state                  <= state_nxt;
            w_high                 <= w_high_nxt;
            k                      <= k_nxt;
            opTxStream.Source      <= SRC;
            opTxStream.Destination <= DEST;
            opTxStream.Length      <= LEN_C;
            opTxStream.Data        <= data_nxt;
            opTxStream.SoP         <= sop_nxt;
            opTxStream.EoP         <= eop_nxt;
            opTxStream.Valid       <= valid_nxt;
        end
    end

endmodule

// File: tb/tb_stream_packetizer.sv
// Scoreboard bench for stream_packetizer: expected bytes are queued as words
// are written and compared as the transmitter side accepts them.

module tb_stream_packetizer;
    import Structures::*;

    logic        ipClk     = 1'b0;
    logic        ipReset   = 1'b0;
    logic [15:0] ipStream  = '0;
    logic        ipValid   = 1'b0;
    logic        ipTxReady = 1'b0;
    logic        opReady;
    UART_PACKET  opTxStream;
    logic [8:0]  opFIFO_Size;
    logic        opOverflow;

    stream_packetizer dut (
        .ipClk       (ipClk),
        .ipReset     (ipReset),
        .ipStream    (ipStream),
        .ipValid     (ipValid),
        .opReady     (opReady),
        .opTxStream  (opTxStream),
        .ipTxReady   (ipTxReady),
        .opFIFO_Size (opFIFO_Size),
        .opOverflow  (opOverflow)
    );

    always #5 ipClk = ~ipClk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // {SoP, EoP, Data} per expected byte
    logic [9:0]  sb [$];
    logic [15:0] rx_q [$];
    int          xfer_cyc [$];
    int          xfer_n   = 0;
    int          wpos     = 0;
    bit          seen_valid = 1'b0;
    bit          prev_stall = 1'b0;
    bit          hi_phase   = 1'b0;
    logic [9:0]  held;
    logic [7:0]  lo_byte;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge ipClk);
        cyc++;
    end

    // Transmitter-side monitor, sampled on the falling edge.
    initial forever begin
        logic [9:0] cur;
        logic [9:0] exp;
        @(negedge ipClk);
        cur = {opTxStream.SoP, opTxStream.EoP, opTxStream.Data};
        if (!ipReset) begin
            prev_stall = 1'b0;
            hi_phase   = 1'b0;
        end else if (opTxStream.Valid) begin
            seen_valid = 1'b1;
            if (prev_stall) check("hold_stable", 32'(cur), 32'(held));
            if (ipTxReady) begin
                if (sb.size() == 0) begin
                    check("extra_byte", 32'(cur), 32'h3ff);
                end else begin
                    exp = sb.pop_front();
                    check("byte", 32'(cur), 32'(exp));
                end
                xfer_cyc.push_back(cyc);
                xfer_n++;
                if (hi_phase) rx_q.push_back({opTxStream.Data, lo_byte});
                else          lo_byte = opTxStream.Data;
                hi_phase   = !hi_phase;
                prev_stall = 1'b0;
            end else begin
                prev_stall = 1'b1;
                held       = cur;
            end
        end else begin
            if (prev_stall) check("hold_valid", 32'd0, 32'd1);
            prev_stall = 1'b0;
        end
    end

    task automatic write_word(input logic [15:0] w, input bit accept);
        ipStream = w;
        ipValid  = 1'b1;
        if (accept) begin
            sb.push_back({(wpos == 0), 1'b0, w[7:0]});
            sb.push_back({1'b0, (wpos == 3), w[15:8]});
            wpos = (wpos + 1) % 4;
        end
        @(posedge ipClk);
        #1;
        ipValid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int i;
        for (i = 0; i < budget && (sb.size() != 0 || opTxStream.Valid); i++) begin
            @(posedge ipClk);
            #1;
        end
        check("drain_in_time", 32'(i < budget), 32'd1);
    endtask

    initial begin
        int         n4;
        int         i;
        logic [3:0] pat;
        logic [15:0] words [8];

        // Reset state
        #1;
        check("rst_valid", 32'(opTxStream.Valid), 32'd0);
        check("rst_size", 32'(opFIFO_Size), 32'd0);
        check("rst_ready", 32'(opReady), 32'd1);
        check("rst_ovf", 32'(opOverflow), 32'd0);
        check("rst_dest", 32'(opTxStream.Destination), 32'd0);
        repeat (2) @(posedge ipClk);
        @(negedge ipClk);
        ipReset = 1'b1;
        @(posedge ipClk);
        #1;
        check("dest", 32'(opTxStream.Destination), 32'h10);
        check("len", 32'(opTxStream.Length), 32'd8);
        check("src", 32'(opTxStream.Source), 32'h00);

        // Basic packet, latency and throughput
        ipTxReady = 1'b1;
        xfer_cyc.delete();
        write_word(16'h1234, 1'b1);
        write_word(16'h5678, 1'b1);
        write_word(16'h9ABC, 1'b1);
        write_word(16'hDEF0, 1'b1);
        n4 = cyc;
        wait_drain(40);
        check("t1_nbytes", 32'(xfer_cyc.size()), 32'd8);
        check("t1_first_cyc", 32'(xfer_cyc[0]), 32'(n4 + 1));
        check("t1_last_cyc", 32'(xfer_cyc[7]), 32'(n4 + 8));
        check("t1_size", 32'(opFIFO_Size), 32'd0);

        // Partial packet waits for its last word
        write_word(16'h0A01, 1'b1);
        write_word(16'h0B02, 1'b1);
        write_word(16'h0C03, 1'b1);
        seen_valid = 1'b0;
        repeat (20) @(posedge ipClk);
        #1;
        check("t2_no_valid", 32'(seen_valid), 32'd0);
        check("t2_size", 32'(opFIFO_Size), 32'd3);
        write_word(16'h0D04, 1'b1);
        wait_drain(40);
        check("t2_size_end", 32'(opFIFO_Size), 32'd0);

        // Backpressure with Ready pattern 1,0,0,1
        pat = 4'b1001;
        write_word(16'hA1B2, 1'b1);
        write_word(16'hC3D4, 1'b1);
        write_word(16'hE5F6, 1'b1);
        write_word(16'h0718, 1'b1);
        for (i = 0; i < 200 && (sb.size() != 0 || opTxStream.Valid); i++) begin
            ipTxReady = pat[i % 4];
            @(posedge ipClk);
            #1;
        end
        check("t3_drain", 32'(i < 200), 32'd1);
        check("t3_size", 32'(opFIFO_Size), 32'd0);

        // Fill to full with the transmitter stalled; one word sits in the output register
        ipTxReady = 1'b0;
        for (int j = 0; j < 257; j++) write_word(16'(j), 1'b1);
        check("t4_ready", 32'(opReady), 32'd0);
        check("t4_full_size", 32'(opFIFO_Size), 32'd256);
        check("t4_ovf_before", 32'(opOverflow), 32'd0);
        write_word(16'hFFFF, 1'b0);
        check("t4_ovf", 32'(opOverflow), 32'd1);
        check("t4_size_after_drop", 32'(opFIFO_Size), 32'd256);
        ipTxReady = 1'b1;
        repeat (64 * 9 + 20) @(posedge ipClk);
        #1;
        check("t4_left_words", 32'(opFIFO_Size), 32'd1);
        check("t4_left_bytes", 32'(sb.size()), 32'd2);
        write_word(16'h0101, 1'b1);
        write_word(16'h0202, 1'b1);
        write_word(16'h0303, 1'b1);
        wait_drain(40);
        check("t4_size_end", 32'(opFIFO_Size), 32'd0);
        check("t4_ovf_sticky", 32'(opOverflow), 32'd1);

        // Reset in the middle of a packet
        xfer_n = 0;
        write_word(16'h1111, 1'b1);
        write_word(16'h2222, 1'b1);
        write_word(16'h3333, 1'b1);
        write_word(16'h4444, 1'b1);
        for (i = 0; i < 50 && xfer_n < 3; i++) begin
            @(posedge ipClk);
            #1;
        end
        check("t5_three_bytes", 32'(xfer_n), 32'd3);
        #2;
        ipReset = 1'b0;
        #1;
        check("t5_valid", 32'(opTxStream.Valid), 32'd0);
        check("t5_size", 32'(opFIFO_Size), 32'd0);
        check("t5_ovf", 32'(opOverflow), 32'd0);
        check("t5_ready", 32'(opReady), 32'd1);
        sb.delete();
        wpos = 0;
        @(negedge ipClk);
        #2;
        ipReset = 1'b1;
        @(posedge ipClk);
        #1;
        write_word(16'h5A5A, 1'b1);
        write_word(16'h6B6B, 1'b1);
        write_word(16'h7C7C, 1'b1);
        write_word(16'h8D8D, 1'b1);
        wait_drain(40);
        check("t5_size_end", 32'(opFIFO_Size), 32'd0);

        // Two back-to-back packets rebuilt into words
        rx_q.delete();
        for (int j = 0; j < 8; j++) begin
            words[j] = 16'($urandom);
            write_word(words[j], 1'b1);
        end
        wait_drain(60);
        check("t6_nwords", 32'(rx_q.size()), 32'd8);
        for (int j = 0; j < 8 && j < rx_q.size(); j++)
            check("t6_word", 32'(rx_q[j]), 32'(words[j]));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
